// File: rtl/apple_slot_bus.sv
// rtl/apple_slot_bus.sv - Apple II motherboard slot bus: select decode, $C800 ownership, soft switches, read mux, IRQ sync
module apple_slot_bus #(
  parameter int NUM_SLOTS = 7
) (
  input  logic                   CLK_14M,
  input  logic                   RESET,
  input  logic                   PH_2,
  input  logic [15:0]            ADDRESS,
  input  logic                   RW_N,
  input  logic [8*NUM_SLOTS-1:0] CARD_DOUT,
  input  logic [NUM_SLOTS-1:0]   CARD_IRQ_N,
  output logic [NUM_SLOTS-1:0]   IO_SELECT_N,
  output logic [NUM_SLOTS-1:0]   DEVICE_SELECT_N,
  output logic                   IO_STROBE_N,
  output logic [7:0]             SLOT_DOUT,
  output logic                   SLOT_DOUT_VALID,
  output logic                   IRQ_N,
  output logic [2:0]             C8_OWNER,
  output logic                   INTCXROM,
  output logic                   SLOTC3ROM
);

  logic       r_ph2;
  logic       r_cycle;
  logic [2:0] r_src;
  logic       r_intc8;
  logic       r_irq_meta;

  logic                 w_start;
  logic [2:0]           w_io_slot;
  logic [2:0]           w_dev_slot;
  logic                 w_io_en;
  logic                 w_dev_hit;
  logic                 w_stb_hit;
  logic                 w_c3_internal;
  logic                 w_cfff;
  logic [2:0]           w_src;
  logic [2:0]           w_mux_src;
  logic [7:0]           w_card_byte;
  logic [NUM_SLOTS-1:0] w_io_sel_n;
  logic [NUM_SLOTS-1:0] w_dev_sel_n;

  assign w_start    = PH_2 & ~r_ph2;
  assign w_io_slot  = ADDRESS[10:8];
  assign w_dev_slot = ADDRESS[6:4];
  assign w_cfff     = (ADDRESS == 16'hCFFF);

  // Decode runs on the live address only at START; the select registers then act as the address latch.
  always_comb begin
    w_io_en = (ADDRESS[15:11] == 5'b11000) && (w_io_slot != 3'd0)
              && (int'(w_io_slot) <= NUM_SLOTS) && !INTCXROM
              && !((w_io_slot == 3'd3) && !SLOTC3ROM);
    w_dev_hit = (ADDRESS[15:7] == 9'b1100_0000_1) && (w_dev_slot != 3'd0)
                && (int'(w_dev_slot) <= NUM_SLOTS);
    w_stb_hit = (ADDRESS[15:11] == 5'b11001) && !INTCXROM && !r_intc8;
    w_c3_internal = (ADDRESS[15:8] == 8'hC3) && !INTCXROM && !SLOTC3ROM;
    w_src = 3'd0;
    if (w_io_en)
      w_src = w_io_slot;
    else if (w_dev_hit)
      w_src = w_dev_slot;
    else if (w_stb_hit)
      w_src = C8_OWNER;
    w_io_sel_n  = '1;
    w_dev_sel_n = '1;
    for (int s = 1; s <= NUM_SLOTS; s++) begin
      if (w_io_en && (w_io_slot == 3'(s)))
        w_io_sel_n[s-1] = 1'b0;
      if (w_dev_hit && (w_dev_slot == 3'(s)))
        w_dev_sel_n[s-1] = 1'b0;
    end
  end

  assign w_mux_src = w_start ? w_src : r_src;

  always_comb begin
    w_card_byte = 8'h00;
    for (int s = 1; s <= NUM_SLOTS; s++) begin
      if (w_mux_src == 3'(s))
        w_card_byte = CARD_DOUT[8*s-1 -: 8];
    end
  end

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      r_ph2           <= 1'b0;
      r_cycle         <= 1'b0;
      r_src           <= 3'd0;
      r_intc8         <= 1'b0;
      r_irq_meta      <= 1'b1;
      IRQ_N           <= 1'b1;
      IO_SELECT_N     <= '1;
      DEVICE_SELECT_N <= '1;
      IO_STROBE_N     <= 1'b1;
      SLOT_DOUT       <= 8'h00;
      SLOT_DOUT_VALID <= 1'b0;
      C8_OWNER        <= 3'd0;
      INTCXROM        <= 1'b0;
      SLOTC3ROM       <= 1'b0;
    end else begin
      r_ph2      <= PH_2;
      r_irq_meta <= &CARD_IRQ_N;
      IRQ_N      <= r_irq_meta;
      if (w_start) begin
        r_cycle         <= 1'b1;
        r_src           <= w_src;
        IO_SELECT_N     <= w_io_sel_n;
        DEVICE_SELECT_N <= w_dev_sel_n;
        IO_STROBE_N     <= ~w_stb_hit;
        SLOT_DOUT_VALID <= RW_N && (w_src != 3'd0);
        if (RW_N && (w_src != 3'd0))
          SLOT_DOUT <= w_card_byte;
        if (!RW_N) begin
          case (ADDRESS)
            16'hC006: INTCXROM  <= 1'b0;
            16'hC007: INTCXROM  <= 1'b1;
            16'hC00A: SLOTC3ROM <= 1'b0;
            16'hC00B: SLOTC3ROM <= 1'b1;
            default: ;
          endcase
        end
        // $CFFF releases the window; the strobe above already used the old owner.
        if (w_cfff) begin
          C8_OWNER <= 3'd0;
          r_intc8  <= 1'b0;
        end else if (w_io_en) begin
          C8_OWNER <= w_io_slot;
        end else if (w_c3_internal) begin
          C8_OWNER <= 3'd0;
          r_intc8  <= 1'b1;
        end
      end else if (!PH_2) begin
        r_cycle         <= 1'b0;
        IO_SELECT_N     <= '1;
        DEVICE_SELECT_N <= '1;
        IO_STROBE_N     <= 1'b1;
        SLOT_DOUT_VALID <= 1'b0;
      end else if (r_cycle && SLOT_DOUT_VALID) begin
        SLOT_DOUT <= w_card_byte;
      end
    end
  end

endmodule

// File: tb/tb_apple_slot_bus.sv
// tb/tb_apple_slot_bus.sv - directed vector bench for apple_slot_bus
module tb_apple_slot_bus;

  logic        CLK_14M = 1'b0;
  logic        RESET;
  logic        PH_2;
  logic [15:0] ADDRESS;
  logic        RW_N;
  logic [55:0] CARD_DOUT;
  logic [6:0]  CARD_IRQ_N;
  logic [6:0]  IO_SELECT_N;
  logic [6:0]  DEVICE_SELECT_N;
  logic        IO_STROBE_N;
  logic [7:0]  SLOT_DOUT;
  logic        SLOT_DOUT_VALID;
  logic        IRQ_N;
  logic [2:0]  C8_OWNER;
  logic        INTCXROM;
  logic        SLOTC3ROM;

  int checks = 0;
  int failures = 0;

  apple_slot_bus #(.NUM_SLOTS(7)) dut (
    .CLK_14M(CLK_14M), .RESET(RESET), .PH_2(PH_2), .ADDRESS(ADDRESS), .RW_N(RW_N),
    .CARD_DOUT(CARD_DOUT), .CARD_IRQ_N(CARD_IRQ_N), .IO_SELECT_N(IO_SELECT_N),
    .DEVICE_SELECT_N(DEVICE_SELECT_N), .IO_STROBE_N(IO_STROBE_N), .SLOT_DOUT(SLOT_DOUT),
    .SLOT_DOUT_VALID(SLOT_DOUT_VALID), .IRQ_N(IRQ_N), .C8_OWNER(C8_OWNER),
    .INTCXROM(INTCXROM), .SLOTC3ROM(SLOTC3ROM)
  );

  always #5 CLK_14M = ~CLK_14M;

  typedef struct {
    logic [15:0] addr;
    logic        rw_n;
    logic [6:0]  io_n;
    logic [6:0]  dev_n;
    logic        stb_n;
    logic        valid;
    logic [7:0]  dout;
    logic [2:0]  own;
    logic        cx;
    logic        c3;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_14M);
    #1;
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic rw, input logic [6:0] io,
                              input logic [6:0] dv, input logic sb, input logic v,
                              input logic [7:0] d, input logic [2:0] o, input logic x,
                              input logic c);
    vec_t r;
    r.addr = a; r.rw_n = rw; r.io_n = io; r.dev_n = dv; r.stb_n = sb;
    r.valid = v; r.dout = d; r.own = o; r.cx = x; r.c3 = c;
    return r;
  endfunction

  task automatic set_card_defaults();
    for (int s = 1; s <= 7; s++)
      CARD_DOUT[8*s-1 -: 8] = 8'(8'h11 * s);
  endtask

  task automatic bus_start(input logic [15:0] a, input logic rw);
    ADDRESS = a;
    RW_N    = rw;
    PH_2    = 1'b1;
    tick();
  endtask

  task automatic bus_end();
    PH_2 = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0]  = mk(16'hC205, 1, 7'b1111101, 7'h7F, 1, 1, 8'h22, 2, 0, 0);
    vecs[1]  = mk(16'hC900, 1, 7'h7F,      7'h7F, 0, 1, 8'h22, 2, 0, 0);
    vecs[2]  = mk(16'hCFFF, 1, 7'h7F,      7'h7F, 0, 1, 8'h22, 0, 0, 0);
    vecs[3]  = mk(16'hC900, 1, 7'h7F,      7'h7F, 0, 0, 8'h00, 0, 0, 0);
    vecs[4]  = mk(16'hC007, 0, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 1, 0);
    vecs[5]  = mk(16'hC600, 1, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 1, 0);
    vecs[6]  = mk(16'hC006, 1, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 1, 0);
    vecs[7]  = mk(16'hC006, 0, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 0, 0);
    vecs[8]  = mk(16'hC600, 1, 7'b1011111, 7'h7F, 1, 1, 8'h66, 6, 0, 0);
    vecs[9]  = mk(16'hC300, 1, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 0, 0);
    vecs[10] = mk(16'hC800, 1, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 0, 0);
    vecs[11] = mk(16'hC00B, 0, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 0, 1);
    vecs[12] = mk(16'hC300, 1, 7'b1111011, 7'h7F, 1, 1, 8'h33, 3, 0, 1);
    vecs[13] = mk(16'hC0C4, 0, 7'h7F, 7'b1110111, 1, 0, 8'h00, 3, 0, 1);
    vecs[14] = mk(16'hC0B3, 1, 7'h7F, 7'b1111011, 1, 1, 8'h33, 3, 0, 1);
    vecs[15] = mk(16'hC805, 1, 7'h7F,      7'h7F, 1, 0, 8'h00, 3, 0, 1);
    vecs[16] = mk(16'hCFFF, 1, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 0, 1);
    vecs[17] = mk(16'hC805, 1, 7'h7F,      7'h7F, 0, 0, 8'h00, 0, 0, 1);
    vecs[18] = mk(16'hC080, 1, 7'h7F,      7'h7F, 1, 0, 8'h00, 0, 0, 1);
    vecs[19] = mk(16'hC205, 1, 7'b1111101, 7'h7F, 1, 1, 8'h22, 2, 0, 1);
    vecs[20] = mk(16'hC805, 1, 7'h7F,      7'h7F, 0, 1, 8'h22, 2, 0, 1);
    vecs[21] = mk(16'hC00A, 0, 7'h7F,      7'h7F, 1, 0, 8'h00, 2, 0, 0);

    RESET = 1'b1; PH_2 = 1'b0; ADDRESS = 16'h0000; RW_N = 1'b1;
    CARD_IRQ_N = 7'h7F;
    set_card_defaults();
    tick(); tick();
    chk("rst_io", 32'(IO_SELECT_N), 32'h7F);
    chk("rst_dev", 32'(DEVICE_SELECT_N), 32'h7F);
    chk("rst_stb", 32'(IO_STROBE_N), 1);
    chk("rst_dout", 32'(SLOT_DOUT), 0);
    chk("rst_valid", 32'(SLOT_DOUT_VALID), 0);
    chk("rst_irq", 32'(IRQ_N), 1);
    chk("rst_own", 32'(C8_OWNER), 0);
    chk("rst_flags", 32'({INTCXROM, SLOTC3ROM}), 0);
    RESET = 1'b0;
    tick();

    // First cycle by hand: select timing and SLOT_DOUT tracking/hold.
    ADDRESS = 16'hC205; RW_N = 1'b1; PH_2 = 1'b1;
    #1;
    chk("pre_start_io", 32'(IO_SELECT_N), 32'h7F);
    tick();
    chk("start_io", 32'(IO_SELECT_N), 32'b1111101);
    chk("start_dout", 32'(SLOT_DOUT), 32'h22);
    tick();
    CARD_DOUT[15:8] = 8'h5A;
    tick();
    chk("track_dout", 32'(SLOT_DOUT), 32'h5A);
    chk("track_valid", 32'(SLOT_DOUT_VALID), 1);
    tick(); tick(); tick(); tick();
    chk("late_io", 32'(IO_SELECT_N), 32'b1111101);
    bus_end();
    chk("end_io", 32'(IO_SELECT_N), 32'h7F);
    chk("end_valid", 32'(SLOT_DOUT_VALID), 0);
    chk("hold_dout", 32'(SLOT_DOUT), 32'h5A);
    set_card_defaults();
    tick();

    for (int i = 0; i < NV; i++) begin
      bus_start(vecs[i].addr, vecs[i].rw_n);
      tick(); tick();
      chk($sformatf("v%0d_io", i), 32'(IO_SELECT_N), 32'(vecs[i].io_n));
      chk($sformatf("v%0d_dev", i), 32'(DEVICE_SELECT_N), 32'(vecs[i].dev_n));
      chk($sformatf("v%0d_stb", i), 32'(IO_STROBE_N), 32'(vecs[i].stb_n));
      chk($sformatf("v%0d_valid", i), 32'(SLOT_DOUT_VALID), 32'(vecs[i].valid));
      if (vecs[i].valid)
        chk($sformatf("v%0d_dout", i), 32'(SLOT_DOUT), 32'(vecs[i].dout));
      chk($sformatf("v%0d_own", i), 32'(C8_OWNER), 32'(vecs[i].own));
      chk($sformatf("v%0d_flags", i), 32'({INTCXROM, SLOTC3ROM}), 32'({vecs[i].cx, vecs[i].c3}));
      tick();
      bus_end();
      chk($sformatf("v%0d_release", i), 32'({IO_SELECT_N, DEVICE_SELECT_N, IO_STROBE_N, SLOT_DOUT_VALID}),
          32'({7'h7F, 7'h7F, 1'b1, 1'b0}));
      tick();
    end

    // IRQ synchronizer latency
    CARD_IRQ_N[4] = 1'b0;
    tick();
    chk("irq_1clk", 32'(IRQ_N), 1);
    tick();
    chk("irq_2clk", 32'(IRQ_N), 0);
    CARD_IRQ_N[4] = 1'b1;
    tick();
    chk("irq_rel_1clk", 32'(IRQ_N), 0);
    tick();
    chk("irq_rel_2clk", 32'(IRQ_N), 1);

    // Asynchronous reset in the middle of a $C205 read
    bus_start(16'hC007, 1'b0); bus_end(); tick();
    bus_start(16'hC00B, 1'b0); bus_end(); tick();
    chk("pre_rst_flags", 32'({INTCXROM, SLOTC3ROM}), 32'b11);
    bus_start(16'hC006, 1'b0); bus_end(); tick();
    bus_start(16'hC205, 1'b1);
    tick();
    chk("pre_rst_io", 32'(IO_SELECT_N), 32'b1111101);
    chk("pre_rst_own", 32'(C8_OWNER), 2);
    #2;
    RESET = 1'b1;
    #1;
    chk("mid_rst_io", 32'(IO_SELECT_N), 32'h7F);
    chk("mid_rst_own", 32'(C8_OWNER), 0);
    chk("mid_rst_flags", 32'({INTCXROM, SLOTC3ROM}), 0);
    chk("mid_rst_valid", 32'(SLOT_DOUT_VALID), 0);
    tick();
    PH_2 = 1'b0;
    RESET = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
